// File: rtl/bn_pkg.sv
// Shared BN parameter-loader definitions: factor codes, loader FSM states and
// the factor/addend legality rule used by the loader and the BN datapath.
package bn_pkg;

    localparam logic [3:0] BN_X1 = 4'b0100;
    localparam logic [3:0] BN_X8 = 4'b0011;

    // Codes the BN datapath has no multiplier mapping for
    localparam logic [3:0] BN_INV0 = 4'b0000;
    localparam logic [3:0] BN_INV1 = 4'b0111;
    localparam logic [3:0] BN_INV2 = 4'b1011;
    localparam logic [3:0] BN_INV3 = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } bn_state_e;

    function automatic logic bn_code_legal(input logic [3:0] factor,
                                           input logic       addend_is_zero);
        logic invalid;
        invalid = (factor == BN_INV0) || (factor == BN_INV1) ||
                  (factor == BN_INV2) || (factor == BN_INV3);
        // x8 saturates unless the addend is zero
        return !invalid && ((factor != BN_X8) || addend_is_zero);
    endfunction

endpackage

// File: rtl/bn_factor_check.sv
// Combinational legality check of a BN factor code / addend pair.
module bn_factor_check
    import bn_pkg::*;
(
    input  logic [3:0] factor,
    input  logic       addend_is_zero,
    output logic       legal
);

    always_comb begin
        legal = bn_code_legal(factor, addend_is_zero);
    end

endmodule

// File: rtl/bn_param_loader.sv
// Bit-serial BN parameter writer: frames land in a shadow bank after a
// legality check; commit copies the whole shadow bank to the active outputs.
module bn_param_loader
    import bn_pkg::*;
#(
    parameter int WIDTH        = 6,
    parameter int ADDEND_WIDTH = WIDTH - 2,
    parameter int N_NEURONS    = 4,
    parameter int ADDR_WIDTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ser_en,
    input  logic                              ser_valid,
    input  logic                              ser_data,
    output logic                              ser_ready,
    input  logic                              commit,
    input  logic                              err_clr,
    output logic [4*N_NEURONS-1:0]            bn_factor_flat,
    output logic [ADDEND_WIDTH*N_NEURONS-1:0] bn_addend_flat,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              err_illegal,
    output logic                              err_addr
);

    localparam int FRAME_BITS = ADDR_WIDTH + 4 + ADDEND_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    bn_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [3:0]              sh_fac_q  [N_NEURONS];
    logic [3:0]              sh_fac_d  [N_NEURONS];
    logic [ADDEND_WIDTH-1:0] sh_add_q  [N_NEURONS];
    logic [ADDEND_WIDTH-1:0] sh_add_d  [N_NEURONS];
    logic [3:0]              act_fac_q [N_NEURONS];
    logic [3:0]              act_fac_d [N_NEURONS];
    logic [ADDEND_WIDTH-1:0] act_add_q [N_NEURONS];
    logic [ADDEND_WIDTH-1:0] act_add_d [N_NEURONS];
    logic                    frame_done_q, frame_done_d;
    logic                    err_illegal_q, err_illegal_d;
    logic                    err_addr_q, err_addr_d;

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   fr_addr;
    logic [3:0]              fr_fac;
    logic [ADDEND_WIDTH-1:0] fr_add;
    logic                    addr_ok;
    logic                    code_ok;

    assign ser_ready = ser_en & (state_q != CHECK);
    assign accept    = ser_en & ser_valid & ser_ready;

    assign fr_addr = sr_q[FRAME_BITS-1 -: ADDR_WIDTH];
    assign fr_fac  = sr_q[ADDEND_WIDTH +: 4];
    assign fr_add  = sr_q[ADDEND_WIDTH-1:0];
    assign addr_ok = (32'(fr_addr) < 32'(N_NEURONS));

    bn_factor_check u_check (
        .factor         (fr_fac),
        .addend_is_zero (fr_add == '0),
        .legal          (code_ok)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        sh_fac_d      = sh_fac_q;
        sh_add_d      = sh_add_q;
        act_fac_d     = act_fac_q;
        act_add_d     = act_add_q;
        frame_done_d  = 1'b0;
        err_illegal_d = err_clr ? 1'b0 : err_illegal_q;
        err_addr_d    = err_clr ? 1'b0 : err_addr_q;

        // Active bank samples the pre-write shadow, so a same-edge write waits for the next commit
        if (commit) begin
            act_fac_d = sh_fac_q;
            act_add_d = sh_add_q;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = {sr_q[FRAME_BITS-2:0], ser_data};
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!ser_en) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    sr_d  = {sr_q[FRAME_BITS-2:0], ser_data};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = CHECK;
                end
            end
            CHECK: begin
                cnt_d   = '0;
                state_d = IDLE;
                if (addr_ok && code_ok) begin
                    sh_fac_d[fr_addr] = fr_fac;
                    sh_add_d[fr_addr] = fr_add;
                    frame_done_d      = 1'b1;
                end else begin
                    if (!addr_ok) err_addr_d    = 1'b1;
                    if (!code_ok) err_illegal_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sr_q          <= '0;
            frame_done_q  <= 1'b0;
            err_illegal_q <= 1'b0;
            err_addr_q    <= 1'b0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                sh_fac_q[i]  <= BN_X1;
                sh_add_q[i]  <= '0;
                act_fac_q[i] <= BN_X1;
                act_add_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            frame_done_q  <= frame_done_d;
            err_illegal_q <= err_illegal_d;
            err_addr_q    <= err_addr_d;
            sh_fac_q      <= sh_fac_d;
            sh_add_q      <= sh_add_d;
            act_fac_q     <= act_fac_d;
            act_add_q     <= act_add_d;
        end
    end

    always_comb begin
        bn_factor_flat = '0;
        bn_addend_flat = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            bn_factor_flat[4*i +: 4]                       = act_fac_q[i];
            bn_addend_flat[ADDEND_WIDTH*i +: ADDEND_WIDTH] = act_add_q[i];
        end
    end

    assign busy        = (state_q != IDLE);
    assign frame_done  = frame_done_q;
    assign err_illegal = err_illegal_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_bn_param_loader.sv
// Directed and randomized frames against a shadow/active bank reference model.
module tb_bn_param_loader;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int FB = 2 + 4 + AW;

    logic            clk = 1'b0;
    logic            rst_n, ser_en, ser_valid, ser_data, commit, err_clr;
    logic            ser_ready, busy, frame_done, err_illegal, err_addr;
    logic [4*N-1:0]  bn_factor_flat;
    logic [AW*N-1:0] bn_addend_flat;

    int total = 0;
    int bad   = 0;

    int m_sh_f [N];
    int m_sh_a [N];
    int m_ac_f [N];
    int m_ac_a [N];
    bit m_err_ill, m_err_addr;

    always #5 clk = ~clk;

    bn_param_loader #(.WIDTH(6), .N_NEURONS(N), .ADDR_WIDTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ser_en         (ser_en),
        .ser_valid      (ser_valid),
        .ser_data       (ser_data),
        .ser_ready      (ser_ready),
        .commit         (commit),
        .err_clr        (err_clr),
        .bn_factor_flat (bn_factor_flat),
        .bn_addend_flat (bn_addend_flat),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_illegal    (err_illegal),
        .err_addr       (err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh_f[i] = 4; m_sh_a[i] = 0;
            m_ac_f[i] = 4; m_ac_a[i] = 0;
        end
        m_err_ill  = 0;
        m_err_addr = 0;
    endtask

    function automatic logic [31:0] exp_fac();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(m_ac_f[i]);
        return v;
    endfunction

    function automatic logic [31:0] exp_add();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v[AW*i +: AW] = AW'(m_ac_a[i]);
        return v;
    endfunction

    task automatic chk_banks(input string tag);
        chk({tag, "_fac"}, 32'(bn_factor_flat), exp_fac());
        chk({tag, "_add"}, 32'(bn_addend_flat), exp_add());
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_ac_f[i] = m_sh_f[i];
            m_ac_a[i] = m_sh_a[i];
        end
        chk_banks("commit");
    endtask

    task automatic shift_bits(input logic [FB-1:0] frame, input int nbits);
        for (int i = FB - 1; i >= FB - nbits; i--) begin
            ser_en = 1'b1; ser_valid = 1'b1; ser_data = frame[i];
            @(posedge clk); #1;
        end
    endtask

    // Sends a whole frame; cmt/clr are asserted during the CHECK cycle
    task automatic send_frame(input int a, input int f, input int d,
                              input bit cmt, input bit clr, input bit hold_valid);
        logic [FB-1:0] frame;
        bit legal, a_bad, c_bad;
        frame = {2'(a), 4'(f), AW'(d)};
        shift_bits(frame, FB);
        chk("busy_check", 32'(busy), 1);
        chk("ready_check", 32'(ser_ready), 0);
        ser_valid = hold_valid; ser_data = 1'b1;
        commit = cmt; err_clr = clr;
        @(posedge clk); #1;
        commit = 1'b0; err_clr = 1'b0; ser_valid = 1'b0;
        a_bad = (a >= N);
        c_bad = (f == 0 || f == 7 || f == 11 || f == 15) || (f == 3 && d != 0);
        legal = !a_bad && !c_bad;
        if (cmt) for (int i = 0; i < N; i++) begin
            m_ac_f[i] = m_sh_f[i]; m_ac_a[i] = m_sh_a[i];
        end
        if (clr) begin m_err_ill = 0; m_err_addr = 0; end
        if (legal) begin m_sh_f[a] = f; m_sh_a[a] = d; end
        if (c_bad) m_err_ill = 1;
        if (a_bad) m_err_addr = 1;
        chk("frame_done", 32'(frame_done), 32'(legal));
        chk("err_illegal", 32'(err_illegal), 32'(m_err_ill));
        chk("err_addr", 32'(err_addr), 32'(m_err_addr));
        chk("busy_after", 32'(busy), 0);
        @(posedge clk); #1;
        chk("frame_done_once", 32'(frame_done), 0);
        chk_banks("post_frame");
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_err_ill = 0; m_err_addr = 0;
        chk("clr_ill", 32'(err_illegal), 0);
        chk("clr_addr", 32'(err_addr), 0);
    endtask

    initial begin
        rst_n = 1'b0; ser_en = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
        commit = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk_banks("reset");
        chk("reset_fac_const", 32'(bn_factor_flat), 32'h4444);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(frame_done), 0);
        chk("reset_ill", 32'(err_illegal), 0);
        chk("reset_addr", 32'(err_addr), 0);
        chk("ready_no_en", 32'(ser_ready), 0);

        // addr 2, x1.5, addend -2
        send_frame(2, 4'b0101, 4'b1110, 0, 0, 0);
        do_commit();
        chk("t1_fac2", 32'(bn_factor_flat[11:8]), 32'h5);
        chk("t1_add2", 32'(bn_addend_flat[11:8]), 32'he);

        // x8 with nonzero addend is rejected
        send_frame(1, 4'b0011, 4'b0001, 0, 0, 0);
        chk("t2_ill", 32'(err_illegal), 1);
        clear_errors();

        // set beats clear on the same edge
        send_frame(0, 4'b1111, 0, 0, 1, 0);
        chk("t2b_ill_kept", 32'(err_illegal), 1);
        clear_errors();

        // aborted partial frame, then a full one
        shift_bits(10'b00_0010_0000, 6);
        chk("abort_busy_mid", 32'(busy), 1);
        ser_en = 1'b0; ser_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 0);
        send_frame(0, 4'b0010, 0, 0, 0, 0);
        do_commit();
        chk("t3_fac0", 32'(bn_factor_flat[3:0]), 32'h2);
        chk("t3_ill", 32'(err_illegal), 0);

        // commit coincident with the shadow write
        send_frame(3, 4'b1100, 4'b0011, 1, 0, 0);
        chk("t4_old", 32'(bn_factor_flat[15:12]), 32'h4);
        do_commit();
        chk("t4_new_fac", 32'(bn_factor_flat[15:12]), 32'hc);
        chk("t4_new_add", 32'(bn_addend_flat[15:12]), 32'h3);

        // ser_valid held through CHECK is not consumed
        send_frame(1, 4'b0110, 4'b0101, 0, 0, 1);

        for (int n = 0; n < 30; n++) begin
            int a, f, d;
            a = $urandom_range(0, N - 1);
            f = $urandom_range(0, 15);
            d = $urandom_range(0, 15);
            if (f == 3 && $urandom_range(0, 1) == 1) d = 0;
            send_frame(a, f, d, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0), 0);
            if ($urandom_range(0, 2) == 0) do_commit();
            if ($urandom_range(0, 3) == 0) clear_errors();
        end
        do_commit();

        // asynchronous reset in the middle of a frame
        send_frame(1, 4'b0111, 0, 0, 0, 0);
        shift_bits(10'b10_1001_0110, 4);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_banks("async_rst");
        chk("async_busy", 32'(busy), 0);
        chk("async_ill", 32'(err_illegal), 0);
        chk("async_done", 32'(frame_done), 0);
        ser_en = 1'b0; ser_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        send_frame(2, 4'b1000, 4'b0111, 0, 0, 0);
        do_commit();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bn_param_loader.md
Name: bn_param_loader

Overview:
Serial configuration writer for the per-neuron batch-normalization parameters (4-bit factor code, signed addend) consumed by the BN datapath of each LIF neuron. It shifts in address/factor/addend frames bit-serially, rejects codes the BN datapath cannot handle, and stages accepted values in a shadow bank. A commit strobe copies the whole shadow bank into the active outputs atomically, so a neuron's parameters never change mid-timestep.

Parameters:
WIDTH, 6, neuron membrane width; sets the addend width.
ADDEND_WIDTH, WIDTH-2, width of the signed BN addend.
N_NEURONS, 4, number of neurons configured.
ADDR_WIDTH, 2, neuron address width; must satisfy 2**ADDR_WIDTH >= N_NEURONS.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ser_en  in  1  frame enable; deassertion aborts the current frame
ser_valid  in  1  ser_data holds a bit this cycle
ser_data  in  1  serial bit, MSB first
ser_ready  out  1  loader accepts a bit this cycle
commit  in  1  one-cycle strobe: shadow bank -> active bank
err_clr  in  1  clears the sticky error flags
bn_factor_flat  out  4*N_NEURONS  active factor codes; neuron i at [4i+3:4i]
bn_addend_flat  out  ADDEND_WIDTH*N_NEURONS  active addends; neuron i at [ADDEND_WIDTH*i +: ADDEND_WIDTH]
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse: frame accepted and written to shadow
err_illegal  out  1  sticky: a frame carried an illegal factor/addend pair
err_addr  out  1  sticky: a frame addressed a neuron index >= N_NEURONS

Behaviour:
- Frame = FRAME_BITS = ADDR_WIDTH+4+ADDEND_WIDTH bits, MSB first: address, factor[3:0], addend. Default is 10 bits.
- A bit is accepted on a rising edge when ser_en & ser_valid & ser_ready.
- ser_ready = ser_en & (state != CHECK).
- FSM:
  - IDLE: on the first accepted bit, go to SHIFT with bit count = 1.
  - SHIFT: count the accepted bits. When bit FRAME_BITS is accepted, go to CHECK.
  - CHECK: lasts exactly one cycle, then returns to IDLE.
  - In SHIFT, if ser_en is low, discard the partial frame, clear the counter and go to IDLE. No error is raised.
- In CHECK the frame is legal when the address is < N_NEURONS and the factor code is not in {0000, 0111, 1011, 1111}. Code 0011 (x8) additionally requires addend == 0.
- Legal frame: on the edge leaving CHECK, write shadow[addr] and pulse frame_done for one cycle.
- Illegal frame: leave the shadow bank unchanged and do not pulse frame_done. Set err_addr (address out of range) and/or err_illegal (bad code or addend).
- If err_clr is asserted in the same cycle an error is being set, the set takes priority.
- Latency: last bit accepted at edge k; CHECK is the cycle after edge k; the shadow write and flags land at edge k+1; frame_done is high for the following cycle.
- commit copies all shadow entries to the active outputs at the next edge. It is allowed in any state.
- commit and a shadow write on the same edge: the active bank takes the pre-write shadow value. The new value reaches the active bank on the next commit.
- Reset, asynchronous and usable mid-frame:
  - All shadow and active factors = 0100 (x1); all addends = 0.
  - FSM = IDLE, bit counter = 0.
  - busy = 0, frame_done = 0, err_illegal = 0, err_addr = 0.
- Outputs are registered only; there are no combinational paths from ser_* to the bn_* outputs.

Decomposition:
- Package bn_pkg holds:
  - the factor code constants: BN_X1 = 4'b0100, BN_X8 = 4'b0011, and the invalid set;
  - the FSM state enum {IDLE, SHIFT, CHECK};
  - the function bn_code_legal(factor, addend_is_zero).
- One sub-module, bn_factor_check: combinational legality check, reused later by the BN datapath's assertions.

Test Plan:
- Reset, then read the outputs -> bn_factor_flat = 16'h4444, bn_addend_flat = 0, busy = 0, both error flags 0.
- Frame 10_0101_1110 (addr 2, x1.5, addend -2), then commit -> frame_done pulses exactly once; after commit bn_factor_flat[11:8] = 0101 and bn_addend_flat[11:8] = 1110; all other entries stay at reset values.
- Frame 01_0011_0001 (x8 with addend 1) -> err_illegal = 1, no frame_done, shadow[1] unchanged. Assert err_clr -> err_illegal = 0.
- ser_en dropped after 6 of 10 bits, then a full frame 00_0010_0000 -> no error; entry 0 = 0010 after commit.
- commit on the same edge as the CHECK-exit write of 11_1100_0011 -> entry 3 keeps its old active value; a second commit yields factor 1100, addend 0011.
- ser_valid held high through CHECK -> ser_ready = 0 for that cycle and that bit is not consumed. rst_n pulsed mid-SHIFT -> FSM returns to IDLE and all outputs are at reset values asynchronously.
